testport_capture_fifo: RTL and testbench
========================================

// Module: testport_capture_fifo
// PURPOSE
//   Upstream of the result checker. Snoops CPU data-memory writes and turns each store to
//   the test port into one clean event: stall-repeated wen collapsed, byte order fixed.
//   Buffers events in a FIFO and presents them to the checker over valid/ready.
//   Marks the begin/end of a test program and flags lost results.
// PARAMETERS
//   PORT_ADDR  30'hFF          word address of the test port
//   BEGIN_SYM  32'h00000168    start marker (readable byte order)
//   END_SYM    32'hFFFFFD5D    end marker (readable byte order)
//   DEPTH      8               FIFO entries; power of 2, >=2
//   AW         3               log2(DEPTH)
// PORTS
//   clk        in   1    single clock, rising edge
//   rst        in   1    asynchronous, active-low reset
//   mem_addr   in   30   CPU D-side word address
//   mem_data   in   32   CPU store data, little-endian byte order
//   mem_wen    in   1    CPU store enable; held high across D-cache stall cycles
//   out_valid  out  1    FIFO head valid
//   out_data   out  32   FIFO head, readable order {d[7:0],d[15:8],d[23:16],d[31:24]}
//   out_ready  in   1    consumer accepts head when out_valid & out_ready
//   armed      out  1    BEGIN_SYM seen, END_SYM not yet captured
//   done       out  1    END_SYM pushed; sticky until reset
//   overflow   out  1    sticky: an event was dropped because the FIFO was full
//   drop_cnt   out  8    dropped events, saturates at 255
// BEHAVIOUR
//   Reset (rst=0, any time, mid-transfer included): FSM=IDLE, FIFO empty, wen_q=0,
//     out_valid=0, out_data=0, armed=0, done=0, overflow=0, drop_cnt=0.
//   Event detect: ev = mem_wen & ~wen_q & (mem_addr==PORT_ADDR); wen_q <= mem_wen each cycle.
//     A wen held N cycles yields one event. A new event needs wen low for >=1 cycle first.
//   swp = byte-swapped mem_data, computed combinationally in the event cycle.
//   FSM states IDLE / RUN / DONE:
//     IDLE: ev & swp==BEGIN_SYM -> RUN, armed=1. The marker is not pushed.
//           Every other event is ignored (no push, no drop count).
//     RUN:  every ev pushes swp. ev & swp==END_SYM -> push, then DONE:
//           armed=0, done=1 in the following cycle.
//           A second BEGIN_SYM in RUN is pushed as ordinary data.
//     DONE: further events are ignored. The FIFO keeps draining. Exit only by reset.
//   FIFO behaviour:
//     Push accepted when not full, or when full and a pop happens in the same cycle.
//     A push while full with no pop drops the event: overflow<=1,
//       drop_cnt<=drop_cnt+1 (saturating). The FSM still reacts to a dropped END_SYM
//       (-> DONE), so done cannot hang.
//     Simultaneous push+pop on empty: the pop is illegal (out_valid=0). The push lands,
//       and out_valid=1 in the next cycle.
//     Latency: ev at cycle t -> out_valid/out_data visible at t+1 (registered, no
//       fall-through).
//     Pop: head advances on out_valid & out_ready. out_data is stable while
//       out_valid & ~out_ready.
//     Pointers: AW+1 bits, wrap naturally. full = MSBs differ & rest equal;
//       empty = pointers equal.
// STRUCTURE
//   Package testport_pkg: PORT_ADDR, BEGIN_SYM, END_SYM defaults; FSM state encoding
//     (2-bit); function byte_swap32.
//   Sub-module sync_fifo #(WIDTH=32, AW) with push/pop/full/empty/count and registered
//     head. The top holds the edge detector, FSM, drop counter and status flags.
// TESTING
//   1 BEGIN_SYM store, then 0x01000000 (LE of 1), then END_SYM, out_ready=1
//     -> out_data 1 then 0xFFFFFD5D; done=1; overflow=0.
//   2 wen held 4 cycles on PORT_ADDR in RUN -> exactly one entry pushed.
//   3 Store to addr 0xFE while armed -> no entry. Stores to 0xFF before BEGIN
//     -> no entry, armed=0.
//   4 out_ready=0, 10 distinct stores (DEPTH=8) -> 8 entries kept in order,
//     overflow=1, drop_cnt=2.
//   5 FIFO full, store coincides with a pop -> push accepted, no drop, order preserved.
//   6 rst pulled low with 3 entries queued and armed=1 -> all outputs return to reset
//     values asynchronously. A new BEGIN then works normally.

Source files
------------

// File: rtl/testport_pkg.sv
// Shared constants, FSM encoding and byte-order helper for the test-port capture path.
package testport_pkg;

  localparam logic [29:0] PORT_ADDR_DEF = 30'hFF;
  localparam logic [31:0] BEGIN_SYM_DEF = 32'h00000168;
  localparam logic [31:0] END_SYM_DEF   = 32'hFFFFFD5D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // CPU stores little-endian; the checker wants the readable order.
  function automatic logic [31:0] byte_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/testport_capture_fifo_if.sv
// CPU store snoop bus plus the valid/ready result stream toward the checker.
interface testport_capture_fifo_if;

  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output mem_addr, mem_data, mem_wen, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  mem_addr, mem_data, mem_wen, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, no fall-through: a push is visible at the head one cycle later.
// A push while full is accepted only if a real pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full with a pop, the write slot is the head being popped this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/testport_capture_fifo.sv
// Turns CPU stores to the test port into single byte-swapped events between BEGIN/END markers,
// queues them for the checker, and tracks events lost to a full queue.
module testport_capture_fifo
  import testport_pkg::*;
#(
  parameter logic [29:0] PORT_ADDR = PORT_ADDR_DEF,
  parameter logic [31:0] BEGIN_SYM = BEGIN_SYM_DEF,
  parameter logic [31:0] END_SYM   = END_SYM_DEF,
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  testport_capture_fifo_if.slave   bus,
  output logic                     armed,
  output logic                     done,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  state_t      state_q;
  state_t      state_d;
  logic        wen_q;
  logic        ev;
  logic [31:0] swp;
  logic        push;
  logic        full;
  logic        empty;
  logic        drop;
  logic [AW:0] unused_count;

  // Stall cycles hold wen high; only the rising edge counts as a store.
  assign ev  = bus.mem_wen & ~wen_q & (bus.mem_addr == PORT_ADDR);
  assign swp = byte_swap32(bus.mem_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= bus.mem_wen;
    end
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: if (ev && swp == BEGIN_SYM) state_d = ST_RUN;
      ST_RUN: begin
        push = ev;
        if (ev && swp == END_SYM) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign armed = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

  sync_fifo #(
    .WIDTH (32),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (swp),
    .pop       (bus.out_ready),
    .head      (bus.out_data),
    .full      (full),
    .empty     (empty),
    .count     (unused_count)
  );

  assign bus.out_valid = ~empty;

  // A full queue still takes a push if the head leaves in the same cycle.
  assign drop = push & full & ~(bus.out_ready & ~empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_testport_capture_fifo.sv
// Directed scenarios for the test-port capture FIFO with hand-computed expectations.
module tb_testport_capture_fifo;

  logic clk;
  logic rst;
  logic armed;
  logic done;
  logic overflow;
  logic [7:0] drop_cnt;
  int checks;
  int failures;

  localparam logic [29:0] PA       = 30'hFF;
  localparam logic [31:0] BEGIN_LE = 32'h68010000;
  localparam logic [31:0] END_LE   = 32'h5DFDFFFF;

  testport_capture_fifo_if bus();

  testport_capture_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .armed    (armed),
    .done     (done),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Raise wen for one edge and leave it high so the caller can check the result.
  task automatic pulse(input logic [29:0] a, input logic [31:0] d);
    bus.mem_addr = a;
    bus.mem_data = d;
    bus.mem_wen  = 1'b1;
    cyc();
  endtask

  task automatic release_wen();
    bus.mem_wen = 1'b0;
    cyc();
  endtask

  task automatic store(input logic [29:0] a, input logic [31:0] d);
    pulse(a, d);
    release_wen();
  endtask

  task automatic do_reset();
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mem_wen = 1'b0; bus.mem_addr = '0; bus.mem_data = '0; bus.out_ready = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%0h exp=0", bus.out_data); end
    checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rst_armed got=%0h exp=0", armed); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%0h exp=0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    do_reset();
    bus.out_ready = 1'b1;
    pulse(PA, BEGIN_LE);
    checks++; if (armed !== 1'b1) begin failures++; $display("FAIL basic_armed got=%0h exp=1", armed); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_begin_not_pushed got=%0h exp=0", bus.out_valid); end
    release_wen();
    pulse(PA, 32'h01000000);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_v1 got=%0h exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h00000001) begin failures++; $display("FAIL basic_d1 got=%0h exp=1", bus.out_data); end
    release_wen();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%0h exp=0", bus.out_valid); end
    pulse(PA, END_LE);
    checks++; if (bus.out_data !== 32'hFFFFFD5D) begin failures++; $display("FAIL basic_end_data got=%0h exp=fffffd5d", bus.out_data); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0h exp=1", done); end
    checks++; if (armed !== 1'b0) begin failures++; $display("FAIL basic_disarmed got=%0h exp=0", armed); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%0h exp=0", overflow); end
    release_wen();
    pulse(PA, 32'h02000000);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_done_ignores got=%0h exp=0", bus.out_valid); end
    release_wen();
  endtask

  task automatic test_stall();
    do_reset();
    store(PA, BEGIN_LE);
    bus.mem_addr = PA; bus.mem_data = 32'h07000000; bus.mem_wen = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    release_wen();
    checks++; if (bus.out_data !== 32'h00000007) begin failures++; $display("FAIL stall_data got=%0h exp=7", bus.out_data); end
    bus.out_ready = 1'b1;
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_single_entry got=%0h exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_filter();
    do_reset();
    store(PA, 32'h01000000);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL filter_idle_push got=%0h exp=0", bus.out_valid); end
    store(30'hFE, BEGIN_LE);
    checks++; if (armed !== 1'b0) begin failures++; $display("FAIL filter_wrong_addr_begin got=%0h exp=0", armed); end
    store(PA, BEGIN_LE);
    checks++; if (armed !== 1'b1) begin failures++; $display("FAIL filter_armed got=%0h exp=1", armed); end
    store(30'hFE, 32'h02000000);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL filter_fe_push got=%0h exp=0", bus.out_valid); end
    store(PA, 32'h03000000);
    checks++; if (bus.out_data !== 32'h00000003) begin failures++; $display("FAIL filter_ff_data got=%0h exp=3", bus.out_data); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    store(PA, BEGIN_LE);
    for (int i = 0; i < 10; i++) begin
      b = 8'hA0 + 8'(i);
      store(PA, {b, 24'h0});
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'hA0 + 8'(i);
      checks++; if (bus.out_data !== {24'h0, b}) begin failures++; $display("FAIL ovf_order%0d got=%0h exp=%0h", i, bus.out_data, {24'h0, b}); end
      cyc();
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0h exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    logic [31:0] exp_q [$];
    do_reset();
    store(PA, BEGIN_LE);
    for (int i = 0; i < 8; i++) begin
      b = 8'hB0 + 8'(i);
      store(PA, {b, 24'h0});
    end
    bus.out_ready = 1'b1;
    pulse(PA, 32'hC0000000);
    bus.out_ready = 1'b0;
    release_wen();
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL fullpop_drop got=%0h/%0d exp=0/0", overflow, drop_cnt); end
    exp_q = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7, 32'hC0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.out_data !== exp_q[i]) begin failures++; $display("FAIL fullpop_order%0d got=%0h exp=%0h", i, bus.out_data, exp_q[i]); end
      cyc();
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fullpop_drained got=%0h exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    store(PA, BEGIN_LE);
    store(PA, 32'h11000000);
    store(PA, 32'h12000000);
    store(PA, 32'h13000000);
    checks++; if (armed !== 1'b1 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0h/%0h exp=1/1", armed, bus.out_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL areset_data got=%0h exp=0", bus.out_data); end
    checks++; if (armed !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL areset_flags got=%0h/%0h exp=0/0", armed, done); end
    cyc();
    rst = 1'b1;
    cyc();
    store(PA, BEGIN_LE);
    checks++; if (armed !== 1'b1) begin failures++; $display("FAIL areset_rearm got=%0h exp=1", armed); end
    store(PA, 32'h01000000);
    checks++; if (bus.out_data !== 32'h00000001) begin failures++; $display("FAIL areset_new_data got=%0h exp=1", bus.out_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_stall();
    test_filter();
    test_overflow();
    test_full_pop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
